// File: rtl/pattern_bank.sv
// pattern_bank: NUM_BUFS serially loadable pattern buffers with a registered active-pattern
// output and a field read/write port. Define PATBANK_ACTIVE_LOCK_EN to block shifts into the active buffer.

module pattern_buf #(
  parameter int BUF_SIZE  = 22,
  parameter int BUF_WIDTH = 8,
  parameter int PTR_W     = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          shift,
  input  logic                          s_in,
  input  logic                          wr_en,
  input  logic [PTR_W-1:0]              wr_ptr,
  input  logic [BUF_WIDTH-1:0]          wr_data,
  output logic [BUF_SIZE*BUF_WIDTH-1:0] chain,
  output logic                          tail_nxt
);
  localparam int N = BUF_SIZE * BUF_WIDTH;

  logic [N-1:0] chain_nxt;

  // shift and wr_en are never both high; the bank resolves that conflict upstream
  always_comb begin
    chain_nxt = chain;
    if (shift)
      chain_nxt = {chain[N-2:0], s_in};
    else if (wr_en)
      for (int k = 0; k < BUF_SIZE; k++)
        if (wr_ptr == PTR_W'(k)) chain_nxt[k*BUF_WIDTH +: BUF_WIDTH] = wr_data;
  end

  assign tail_nxt = chain_nxt[N-1];

  always_ff @(posedge clk) begin
    if (reset) chain <= '0;
    else       chain <= chain_nxt;
  end
endmodule

module pattern_bank #(
  parameter int BUF_SIZE  = 22,
  parameter int BUF_WIDTH = 8,
  parameter int NUM_BUFS  = 8,
  parameter int PTR_W     = 5,
  parameter int SADDR_W   = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [SADDR_W-1:0]            s_addr,
  input  logic                          s_en,
  input  logic                          s_in,
  output logic                          s_out,
  input  logic [NUM_BUFS-1:0]           buf_select,
  output logic [BUF_SIZE*BUF_WIDTH-1:0] cur_buf,
  output logic                          sel_err,
  input  logic                          rd_req,
  input  logic [NUM_BUFS-1:0]           rd_buf,
  input  logic [PTR_W-1:0]              rd_ptr,
  output logic [BUF_WIDTH-1:0]          rd_data,
  output logic                          rd_valid,
  output logic                          rd_err,
  input  logic                          wr_en,
  input  logic [NUM_BUFS-1:0]           wr_buf,
  input  logic [PTR_W-1:0]              wr_ptr,
  input  logic [BUF_WIDTH-1:0]          wr_data,
  output logic                          wr_drop
`ifdef PATBANK_ACTIVE_LOCK_EN
  ,
  output logic                          lock_hit
`endif
);
  localparam int N = BUF_SIZE * BUF_WIDTH;

  typedef struct packed {
    logic [BUF_WIDTH-1:0] data;
    logic                 err;
  } rd_rsp_t;

  logic [NUM_BUFS-1:0][N-1:0] bufs;
  logic [NUM_BUFS-1:0]        tail_nxt, addr_hit, shift_vec, wr_vec;
  logic                       addr_ok, sel_oh, lock_sup, shift_go, wr_ok;
  logic [N-1:0]               cur_nxt;
  rd_rsp_t                    rd_rsp;

  assign addr_ok = 32'(s_addr) < NUM_BUFS;
  assign sel_oh  = $onehot(buf_select);

  always_comb begin
    addr_hit = '0;
    for (int b = 0; b < NUM_BUFS; b++) addr_hit[b] = (s_addr == SADDR_W'(b));
  end

`ifdef PATBANK_ACTIVE_LOCK_EN
  assign lock_sup = s_en && addr_ok && sel_oh && |(addr_hit & buf_select);
`else
  assign lock_sup = 1'b0;
`endif

  assign shift_go  = s_en && addr_ok && !lock_sup;
  assign shift_vec = shift_go ? addr_hit : '0;

  // a shift into the target buffer wins over a same-cycle field write
  assign wr_ok  = wr_en && $onehot(wr_buf) && (32'(wr_ptr) < BUF_SIZE) && !(|(shift_vec & wr_buf));
  assign wr_vec = wr_ok ? wr_buf : '0;

  for (genvar b = 0; b < NUM_BUFS; b++) begin : g_buf
    pattern_buf #(.BUF_SIZE(BUF_SIZE), .BUF_WIDTH(BUF_WIDTH), .PTR_W(PTR_W)) u_buf (
      .clk      (clk),
      .reset    (reset),
      .shift    (shift_vec[b]),
      .s_in     (s_in),
      .wr_en    (wr_vec[b]),
      .wr_ptr   (wr_ptr),
      .wr_data  (wr_data),
      .chain    (bufs[b]),
      .tail_nxt (tail_nxt[b])
    );
  end

  always_comb begin
    cur_nxt = '0;
    for (int b = 0; b < NUM_BUFS; b++)
      if (buf_select[b]) cur_nxt |= bufs[b];
  end

  // read sees pre-edge storage, so same-cycle writes/shifts are not visible
  always_comb begin
    rd_rsp.err  = !$onehot(rd_buf) || (32'(rd_ptr) >= BUF_SIZE);
    rd_rsp.data = '0;
    if (!rd_rsp.err)
      for (int b = 0; b < NUM_BUFS; b++)
        for (int k = 0; k < BUF_SIZE; k++)
          if (rd_buf[b] && rd_ptr == PTR_W'(k))
            rd_rsp.data |= bufs[b][k*BUF_WIDTH +: BUF_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_buf  <= '0;
      sel_err  <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      wr_drop  <= 1'b0;
      s_out    <= 1'b0;
`ifdef PATBANK_ACTIVE_LOCK_EN
      lock_hit <= 1'b0;
`endif
    end else begin
      sel_err  <= !sel_oh;
      if (sel_oh) cur_buf <= cur_nxt;
      rd_valid <= rd_req;
      rd_err   <= rd_req && rd_rsp.err;
      if (rd_req) rd_data <= rd_rsp.data;
      wr_drop  <= wr_en && !wr_ok;
      if (!lock_sup) s_out <= addr_ok && |(addr_hit & tail_nxt);
`ifdef PATBANK_ACTIVE_LOCK_EN
      lock_hit <= lock_sup;
`endif
    end
  end
endmodule

// File: tb/tb_pattern_bank.sv
// Self-checking bench for pattern_bank: directed scenarios plus random traffic against a
// buffer-level reference model.
module tb_pattern_bank;
  localparam int BS = 22, BW = 8, NB = 8, PW = 5, SW = 3, N = BS * BW;

  logic          clk = 1'b0, reset;
  logic [SW-1:0] s_addr;
  logic          s_en, s_in, s_out;
  logic [NB-1:0] buf_select, rd_buf, wr_buf;
  logic [N-1:0]  cur_buf;
  logic          sel_err, rd_req, rd_valid, rd_err, wr_en, wr_drop;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [BW-1:0] rd_data, wr_data;
  logic          lock_hit_w;

  always #5 clk = ~clk;

  pattern_bank #(.BUF_SIZE(BS), .BUF_WIDTH(BW), .NUM_BUFS(NB), .PTR_W(PW), .SADDR_W(SW)) dut (
    .clk(clk), .reset(reset), .s_addr(s_addr), .s_en(s_en), .s_in(s_in), .s_out(s_out),
    .buf_select(buf_select), .cur_buf(cur_buf), .sel_err(sel_err),
    .rd_req(rd_req), .rd_buf(rd_buf), .rd_ptr(rd_ptr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_err(rd_err),
    .wr_en(wr_en), .wr_buf(wr_buf), .wr_ptr(wr_ptr), .wr_data(wr_data), .wr_drop(wr_drop)
`ifdef PATBANK_ACTIVE_LOCK_EN
    , .lock_hit(lock_hit_w)
`endif
  );
`ifndef PATBANK_ACTIVE_LOCK_EN
  assign lock_hit_w = 1'b0;
`endif

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: each buffer is a 176-bit number, entry k = bits [k*8 +: 8]
  logic [N-1:0]  mdl [NB];
  logic [N-1:0]  e_cur;
  logic [BW-1:0] e_rdd;
  logic          e_sel, e_rdv, e_rde, e_drop, e_sout, e_lock;

  function automatic int idx_of(input logic [NB-1:0] v);
    for (int i = 0; i < NB; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic cyc();
    logic [N-1:0] nb [NB];
    logic lock, shift, ok;
    for (int i = 0; i < NB; i++) nb[i] = mdl[i];
    if (reset) begin
      for (int i = 0; i < NB; i++) nb[i] = '0;
      e_cur = '0; e_rdd = '0; e_sel = 0; e_rdv = 0; e_rde = 0; e_drop = 0; e_sout = 0; e_lock = 0;
    end else begin
      if ($onehot(buf_select)) e_cur = mdl[idx_of(buf_select)];
      e_sel = !$onehot(buf_select);
      e_rdv = rd_req;
      e_rde = 0;
      if (rd_req) begin
        ok = $onehot(rd_buf) && (int'(rd_ptr) < BS);
        e_rde = !ok;
        e_rdd = ok ? mdl[idx_of(rd_buf)][rd_ptr*BW +: BW] : '0;
      end
`ifdef PATBANK_ACTIVE_LOCK_EN
      lock = s_en && (int'(s_addr) < NB) && $onehot(buf_select) && buf_select[s_addr];
`else
      lock = 0;
`endif
      e_lock = lock;
      shift = s_en && (int'(s_addr) < NB) && !lock;
      if (shift) nb[s_addr] = (mdl[s_addr] << 1) | N'(s_in);
      e_drop = 0;
      if (wr_en) begin
        ok = $onehot(wr_buf) && (int'(wr_ptr) < BS) && !(shift && wr_buf[s_addr]);
        if (ok) nb[idx_of(wr_buf)][wr_ptr*BW +: BW] = wr_data;
        e_drop = !ok;
      end
      if (int'(s_addr) < NB) begin
        if (!lock) e_sout = nb[s_addr][N-1];
      end else e_sout = 0;
    end
    for (int i = 0; i < NB; i++) mdl[i] = nb[i];
    @(posedge clk);
    #1;
    chk("cur_buf", cur_buf, e_cur);
    chk("sel_err", sel_err, e_sel);
    chk("rd_valid", rd_valid, e_rdv);
    chk("rd_err", rd_err, e_rde);
    chk("rd_data", rd_data, e_rdd);
    chk("wr_drop", wr_drop, e_drop);
    chk("s_out", s_out, e_sout);
    chk("lock_hit", lock_hit_w, e_lock);
  endtask

  task automatic idle();
    s_en = 0; s_in = 0; rd_req = 0; wr_en = 0;
  endtask

  logic [7:0] pat;
  bit         sent [$];
  int         lock_cnt;

  initial begin
    reset = 1; s_addr = 0; buf_select = 0; rd_buf = 0; rd_ptr = 0;
    wr_buf = 0; wr_ptr = 0; wr_data = 0; idle();
    for (int i = 0; i < NB; i++) mdl[i] = '0;
    cyc(); cyc();
    chk("rst_cur", cur_buf, '0);
    chk("rst_sout", s_out, 1'b0);
    reset = 0;

    // load 0xA5 into every entry of buffer 3, MSB of each entry first
    pat = 8'hA5; s_addr = 3; s_en = 1;
    for (int i = 0; i < N; i++) begin s_in = pat[7 - (i % 8)]; cyc(); end
    s_en = 0; buf_select = 8'b0000_1000; cyc(); cyc();
    chk("t1_cur", cur_buf, {22{8'hA5}});
    rd_req = 1; rd_buf = 8'h01; rd_ptr = 10; cyc();
    chk("t1_other0", rd_data, 8'h00);
    rd_buf = 8'h80; rd_ptr = 21; cyc();
    chk("t1_other7", rd_data, 8'h00);
    rd_req = 0;

    // field write then read, including out-of-range pointer
    wr_en = 1; wr_buf = 8'b0000_0100; wr_ptr = 21; wr_data = 8'h3C; cyc();
    wr_en = 0; rd_req = 1; rd_buf = 8'b0000_0100; rd_ptr = 21; cyc();
    chk("t2_data", rd_data, 8'h3C); chk("t2_vld", rd_valid, 1'b1); chk("t2_err", rd_err, 1'b0);
    rd_ptr = 22; cyc();
    chk("t2_bad_data", rd_data, 8'h00); chk("t2_bad_err", rd_err, 1'b1);
    rd_req = 0;

    // shift/write collision on buffer 1, then shift on a different buffer
    wr_en = 1; wr_buf = 8'b0000_0010; wr_ptr = 0; wr_data = 8'hFF;
    s_en = 1; s_addr = 1; s_in = 1; cyc();
    chk("t3_drop", wr_drop, 1'b1);
    idle(); rd_req = 1; rd_buf = 8'b0000_0010; rd_ptr = 0; cyc();
    chk("t3_shifted", rd_data, 8'h01);
    rd_req = 0; wr_en = 1; s_en = 1; s_addr = 2; s_in = 0; cyc();
    chk("t3_nodrop", wr_drop, 1'b0);
    idle(); rd_req = 1; cyc();
    chk("t3_landed", rd_data, 8'hFF);
    rd_req = 0;

    // multi-hot select holds cur_buf
    buf_select = 8'b0000_0001; cyc(); cyc();
    buf_select = 8'b0000_0011; cyc();
    chk("t4_sel_err", sel_err, 1'b1);
    chk("t4_hold", cur_buf, mdl[0]);
    buf_select = 8'b0000_0001; cyc();
    chk("t4_sel_clr", sel_err, 1'b0);

    // reset mid-shift, then full reload and readback through s_out
    pat = 8'h5A; s_addr = 4; s_en = 1;
    for (int i = 0; i < 80; i++) begin s_in = pat[7 - (i % 8)]; cyc(); end
    reset = 1; cyc();
    chk("t5_rst_cur", cur_buf, '0); chk("t5_rst_sout", s_out, 1'b0); chk("t5_rst_vld", rd_valid, 1'b0);
    reset = 0;
    for (int i = 0; i < N; i++) begin s_in = pat[7 - (i % 8)]; sent.push_back(s_in); cyc(); end
    chk("t5_first", s_out, sent[0]);
    s_in = 0;
    for (int i = 1; i < N; i++) begin cyc(); chk("t5_readback", s_out, sent[i]); end
    s_en = 0; cyc();

    // shifting into the active buffer
    buf_select = 8'b0000_0001; s_addr = 0; s_en = 1; s_in = 1; lock_cnt = 0;
    for (int i = 0; i < 10; i++) begin cyc(); lock_cnt += int'(lock_hit_w); end
    s_en = 0; cyc(); cyc();
`ifdef PATBANK_ACTIVE_LOCK_EN
    chk("t6_locked", cur_buf, '0);
    chk("t6_lock_cnt", 32'(lock_cnt), 32'd10);
`else
    chk("t6_changed", cur_buf, 176'h3FF);
`endif

    // random traffic
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      s_en = $urandom_range(0, 1); s_addr = SW'($urandom); s_in = $urandom_range(0, 1);
      buf_select = ($urandom_range(0, 4) != 0) ? NB'(1 << $urandom_range(0, NB-1)) : NB'($urandom);
      rd_req = $urandom_range(0, 1);
      rd_buf = ($urandom_range(0, 4) != 0) ? NB'(1 << $urandom_range(0, NB-1)) : NB'($urandom);
      rd_ptr = PW'($urandom_range(0, BS+1));
      wr_en = $urandom_range(0, 1);
      wr_buf = ($urandom_range(0, 4) != 0) ? NB'(1 << $urandom_range(0, NB-1)) : NB'($urandom);
      wr_ptr = PW'($urandom_range(0, BS+1)); wr_data = BW'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pattern_bank.md
Name: pattern_bank

Overview:
Parametrised bank of NUM_BUFS pattern buffers. Each buffer holds BUF_SIZE entries of BUF_WIDTH bits. The bank provides:
- a bit-serial load/readback chain per buffer;
- a one-hot active-buffer select that drives a registered, full-width current-pattern output;
- a pipelined single-entry field read port and a field write port.
It sits between the serial configuration interface and the pattern sequencer, and replaces the fixed 8-buffer bank with a fully synchronous, registered-output bank that has error reporting.

Parameters:
BUF_SIZE, 22, entries per buffer
BUF_WIDTH, 8, bits per entry
NUM_BUFS, 8, number of buffers (2..16)
PTR_W, 5, entry pointer width; must satisfy 2^PTR_W >= BUF_SIZE
SADDR_W, 3, serial buffer address width; must satisfy 2^SADDR_W >= NUM_BUFS

Ports:
clk  in  1  system clock; all state on rising edge
reset  in  1  synchronous, active-high reset
s_addr  in  SADDR_W  buffer addressed by the serial chain
s_en  in  1  shift strobe; one bit shifted per cycle while high
s_in  in  1  serial data in
s_out  out  1  serial data out of the addressed buffer
buf_select  in  NUM_BUFS  one-hot active-buffer select
cur_buf  out  BUF_SIZE*BUF_WIDTH  registered contents of the active buffer; entry k at bits [k*BUF_WIDTH +: BUF_WIDTH]
sel_err  out  1  one-cycle pulse when buf_select is not one-hot
rd_req  in  1  field read request
rd_buf  in  NUM_BUFS  one-hot buffer for read
rd_ptr  in  PTR_W  entry index for read
rd_data  out  BUF_WIDTH  read data
rd_valid  out  1  read data valid pulse
rd_err  out  1  read error pulse
wr_en  in  1  field write strobe
wr_buf  in  NUM_BUFS  one-hot buffer for write
wr_ptr  in  PTR_W  entry index for write
wr_data  in  BUF_WIDTH  write data
wr_drop  out  1  pulse when a write is discarded

Behaviour:
Clock and reset:
- Single clock clk; reset is synchronous, active-high.
- While reset is high, all storage, cur_buf, rd_data, rd_valid, rd_err, sel_err, wr_drop and s_out go to 0.
- Reset mid-shift or mid-read aborts the operation; no partial update survives.

Serial chain:
- Each buffer is one chain of BUF_SIZE*BUF_WIDTH bits, entry 0 bit 0 at the input end.
- On s_en && s_addr < NUM_BUFS, the addressed chain shifts by one: s_in enters entry 0 bit 0, and each bit moves up one position.
- s_out is registered and equals the chain's last bit (entry BUF_SIZE-1 bit BUF_WIDTH-1) as it stands after the edge.
- s_addr >= NUM_BUFS means no shift, and s_out reads 0.

Active select:
- cur_buf is updated every cycle from the buffer selected by buf_select, giving 1-cycle latency; it therefore reflects shifts and writes into the active buffer one cycle later.
- If buf_select is zero or multi-hot: cur_buf holds its previous value and sel_err is high for that cycle (registered).

Field read:
- On rd_req, rd_data and rd_valid are presented on the next cycle (latency 1).
- The read sees storage before any same-cycle write or shift (read-before-write).
- rd_ptr >= BUF_SIZE, or rd_buf not one-hot: rd_data = 0, rd_valid = 1, rd_err = 1.
- rd_data holds its value between reads.

Field write:
- On wr_en with one-hot wr_buf and wr_ptr < BUF_SIZE, the entry is updated at the edge.
- Invalid pointer or invalid buffer: the write is ignored and wr_drop pulses.
- A serial shift into the same buffer in the same cycle takes priority: the write is discarded and wr_drop pulses. Writes to other buffers proceed.

Optional Feature:
PATBANK_ACTIVE_LOCK_EN
- Defined: serial shifts into the buffer currently selected by buf_select are suppressed; s_out does not change; a registered output port lock_hit (1 bit, reset 0) pulses for each suppressed shift. Field writes to the active buffer remain allowed.
- Undefined: shifts into the active buffer are allowed, cur_buf follows them with 1-cycle latency, and the lock_hit port does not exist.

Test Plan:
1. Reset, then shift 176 bits of pattern 0xA5 per entry into buffer 3 (s_addr=3); set buf_select=8'b00001000 -> one cycle later every cur_buf entry = 0xA5; all other buffers read 0.
2. Write wr_buf=8'b00000100, wr_ptr=21, wr_data=0x3C; next cycle rd_req to the same address -> rd_data=0x3C, rd_valid=1, rd_err=0. Repeat with rd_ptr=22 -> rd_data=0, rd_err=1.
3. Same cycle: wr_en to buffer 1 entry 0 with 0xFF, and s_en with s_addr=1 -> wr_drop=1, and entry 0 holds the shifted value, not 0xFF. Repeat with s_addr=2 -> write lands, wr_drop=0.
4. buf_select=8'b00000011 after selecting buffer 0 -> sel_err pulses one cycle and cur_buf still equals buffer 0's contents.
5. Assert reset for one cycle in the middle of a 176-bit shift -> all outputs 0 next cycle; a full reshift of 0x5A then reads back correctly on s_out with the first bit out equal to the first bit in, after 176 shifts.
6. With PATBANK_ACTIVE_LOCK_EN defined, buf_select=buffer 0, shift s_addr=0 ten times -> buffer 0 unchanged and lock_hit pulses ten times. Without the macro -> buffer 0 changes.
